// File: rtl/core_wb_bridge.sv
// Registered bridge from a core valid/ready memory port to a single-master classic Wishbone bus.
// One request in flight at a time; a watchdog terminates bus cycles that are never acknowledged.
module core_wb_bridge #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int unsigned           TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    core_valid_i,
  input  logic                    core_we_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  input  logic [DATA_WIDTH-1:0]   core_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] core_wstrb_i,
  output logic                    core_ready_o,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  output logic                    core_err_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_reg,    state_next;
  logic [CNT_W-1:0]      wdog_cnt_reg, wdog_cnt_next;
  logic                  cyc_reg,      cyc_next;
  logic                  we_reg,       we_next;
  logic [SEL_W-1:0]      sel_reg,      sel_next;
  logic [ADDR_WIDTH-1:0] adr_reg,      adr_next;
  logic [DATA_WIDTH-1:0] wdat_reg,     wdat_next;
  logic                  ready_reg,    ready_next;
  logic [DATA_WIDTH-1:0] rdata_reg,    rdata_next;
  logic                  err_reg,      err_next;
  logic                  wdog_expire;

  // Expiry fires on the edge that closes BUS cycle number TIMEOUT_CYCLES.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_wdog
      assign wdog_expire = 1'b0;
    end else begin : g_wdog
      assign wdog_expire = (32'(wdog_cnt_reg) + 32'd1) >= TIMEOUT_CYCLES;
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    wdog_cnt_next = wdog_cnt_reg;
    cyc_next      = cyc_reg;
    we_next       = we_reg;
    sel_next      = sel_reg;
    adr_next      = adr_reg;
    wdat_next     = wdat_reg;
    ready_next    = 1'b0;
    rdata_next    = rdata_reg;
    err_next      = err_reg;

    case (state_reg)
      ST_IDLE: begin
        if (core_valid_i) begin
          state_next    = ST_BUS;
          wdog_cnt_next = '0;
          cyc_next      = 1'b1;
          we_next       = core_we_i;
          sel_next      = core_we_i ? core_wstrb_i : {SEL_W{1'b1}};
          adr_next      = core_addr_i;
          wdat_next     = core_wdata_i;
        end
      end

      ST_BUS: begin
        // Ack is checked first so that an ack on the expiry edge still completes cleanly.
        if (wb_ack_i) begin
          state_next = ST_DONE;
          cyc_next   = 1'b0;
          ready_next = 1'b1;
          rdata_next = we_reg ? '0 : wb_dat_i;
          err_next   = 1'b0;
        end else if (wdog_expire) begin
          state_next = ST_DONE;
          cyc_next   = 1'b0;
          ready_next = 1'b1;
          rdata_next = we_reg ? '0 : ERR_DATA;
          err_next   = 1'b1;
        end else if (wdog_cnt_reg != CNT_MAX) begin
          wdog_cnt_next = wdog_cnt_reg + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
        cyc_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      wdog_cnt_reg <= '0;
      cyc_reg      <= 1'b0;
      we_reg       <= 1'b0;
      sel_reg      <= '0;
      adr_reg      <= '0;
      wdat_reg     <= '0;
      ready_reg    <= 1'b0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wdog_cnt_reg <= wdog_cnt_next;
      cyc_reg      <= cyc_next;
      we_reg       <= we_next;
      sel_reg      <= sel_next;
      adr_reg      <= adr_next;
      wdat_reg     <= wdat_next;
      ready_reg    <= ready_next;
      rdata_reg    <= rdata_next;
      err_reg      <= err_next;
    end
  end

  assign wb_cyc_o     = cyc_reg;
  assign wb_stb_o     = cyc_reg;
  assign wb_we_o      = we_reg;
  assign wb_sel_o     = sel_reg;
  assign wb_adr_o     = adr_reg;
  assign wb_dat_o     = wdat_reg;
  assign core_ready_o = ready_reg;
  assign core_rdata_o = rdata_reg;
  assign core_err_o   = err_reg;

endmodule
